// File: rtl/nw_output_vc_credit_tracker.sv
// Credit and allocation tracker for the downstream VCs of one router output port.
// Optional NW_VC_CREDIT_LOOKAHEAD_EN registers vc_status from the next-state counter.

module nw_ovc_lane #(
    parameter int buf_len = 4,
    parameter int cw      = $clog2(buf_len + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    input  logic          tail,
    input  logic          alloc,
    output logic [cw-1:0] cnt,
    output logic          free,
    output logic          status,
    output logic          err_ev
);
    typedef enum logic [1:0] {FREE = 2'd0, ALLOC = 2'd1, DRAIN = 2'd2} vc_state_e;

    localparam logic [cw-1:0] FULL = cw'(buf_len);

    vc_state_e     st_q, st_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic          cnt_err, fsm_err;

    // A sent flit and a returned credit on the same VC cancel out.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_err = 1'b0;
        if (dec && !inc) begin
            if (cnt_q == '0) cnt_err = 1'b1;
            else             cnt_d   = cnt_q - cw'(1);
        end else if (inc && !dec) begin
            if (cnt_q == FULL) cnt_err = 1'b1;
            else               cnt_d   = cnt_q + cw'(1);
        end
    end

    // Free/drain decisions look at the next counter so a VC frees the edge its last credit lands.
    always_comb begin
        st_d    = st_q;
        fsm_err = 1'b0;
        case (st_q)
            FREE: begin
                if (alloc) st_d    = ALLOC;
                if (dec)   fsm_err = 1'b1;
            end
            ALLOC: begin
                if (alloc) fsm_err = 1'b1;
                if (dec && tail) st_d = (cnt_d == FULL) ? FREE : DRAIN;
            end
            DRAIN: begin
                if (alloc || dec) fsm_err = 1'b1;
                if (cnt_d == FULL) st_d = FREE;
            end
            default: st_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= FULL;
            st_q  <= FREE;
        end else begin
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

`ifdef NW_VC_CREDIT_LOOKAHEAD_EN
    logic status_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_q <= 1'b0;
        else     status_q <= (cnt_d == '0);
    end
    assign status = status_q;
`else
    assign status = (cnt_q == '0);
`endif

    assign cnt    = cnt_q;
    assign free   = (st_q == FREE);
    assign err_ev = cnt_err | fsm_err;
endmodule

module nw_output_vc_credit_tracker #(
    parameter int nv      = 4,
    parameter int buf_len = 4,
    localparam int cw     = $clog2(buf_len + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flit_sent,
    input  logic [nv-1:0]    flit_vc,
    input  logic             flit_tail,
    input  logic             credit_valid,
    input  logic [nv-1:0]    credit_vc,
    input  logic [nv-1:0]    vc_alloc,
    output logic [nv-1:0]    vc_status,
    output logic [nv-1:0]    vc_free,
    output logic [nv-1:0]    next_free_vc,
    output logic             free_vc_blocked,
    output logic [nv*cw-1:0] credit_count,
    output logic             err
);
    logic [nv-1:0] lane_err;
    logic          multi_alloc;

    // More than one grant bit set: nobody moves, only the error flag records it.
    assign multi_alloc = |(vc_alloc & (vc_alloc - nv'(1)));

    for (genvar v = 0; v < nv; v++) begin : g_lane
        nw_ovc_lane #(.buf_len(buf_len), .cw(cw)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .dec    (flit_sent & flit_vc[v]),
            .inc    (credit_valid & credit_vc[v]),
            .tail   (flit_tail),
            .alloc  (vc_alloc[v] & ~multi_alloc),
            .cnt    (credit_count[v*cw +: cw]),
            .free   (vc_free[v]),
            .status (vc_status[v]),
            .err_ev (lane_err[v])
        );
    end

    // Lowest set bit of the free mask.
    assign next_free_vc    = vc_free & (~vc_free + nv'(1));
    assign free_vc_blocked = ~|vc_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= err | multi_alloc | (|lane_err);
    end
endmodule
